// File: rtl/pipelined_addsub.sv
// Pipelined WIDTH-bit adder/subtractor: one CHUNK-bit ripple slice per stage,
// carry registered between stages, valid/ready handshake with a global stall.
module pipelined_addsub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int STAGES = WIDTH / CHUNK;

  logic [STAGES-1:0] vld_q, vld_d;
  logic [STAGES-1:0] c_q, c_d;
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  a_d [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  b_d [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];
  logic [WIDTH-1:0]  s_d [STAGES];
  logic              ovf_q, ovf_d;
  logic              zero_q, zero_d;
  logic              advance;

  logic [WIDTH-1:0]  src_a [STAGES];
  logic [WIDTH-1:0]  src_b [STAGES];
  logic [WIDTH-1:0]  src_s [STAGES];
  logic [STAGES-1:0] src_c;
  logic [STAGES-1:0] src_v;

  // Returns {carry into slice MSB, carry out, CHUNK sum bits}.
  function automatic logic [CHUNK+1:0] ripple_slice(input logic [CHUNK-1:0] x,
                                                    input logic [CHUNK-1:0] y,
                                                    input logic             ci);
    logic [CHUNK-1:0] s;
    logic             c;
    logic             c_prev;
    s      = '0;
    c      = ci;
    c_prev = ci;
    for (int i = 0; i < CHUNK; i++) begin
      c_prev = c;
      s[i]   = x[i] ^ y[i] ^ c;
      c      = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    return {c_prev, c, s};
  endfunction

  // Stage 0 takes the new operands (b pre-inverted for subtract); later
  // stages take their predecessor's registers.
  always_comb begin
    src_a[0] = a;
    src_b[0] = sub ? ~b : b;
    src_s[0] = '0;
    src_c[0] = sub | cin;
    src_v[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      src_a[k] = a_q[k-1];
      src_b[k] = b_q[k-1];
      src_s[k] = s_q[k-1];
      src_c[k] = c_q[k-1];
      src_v[k] = vld_q[k-1];
    end
  end

  always_comb begin
    logic [CHUNK+1:0] r;
    r       = '0;
    advance = !vld_q[STAGES-1] || out_ready;
    vld_d   = vld_q;
    c_d     = c_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    if (advance) begin
      for (int k = 0; k < STAGES; k++) begin
        r = ripple_slice(src_a[k][k*CHUNK +: CHUNK], src_b[k][k*CHUNK +: CHUNK], src_c[k]);
        a_d[k]   = src_a[k];
        b_d[k]   = src_b[k];
        s_d[k]   = src_s[k];
        s_d[k][k*CHUNK +: CHUNK] = r[CHUNK-1:0];
        c_d[k]   = r[CHUNK];
        vld_d[k] = src_v[k];
      end
      // r now holds the final slice, whose carries bracket the word MSB.
      ovf_d  = r[CHUNK+1] ^ r[CHUNK];
      zero_d = (s_d[STAGES-1] == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      c_q    <= '0;
      a_q    <= '{default: '0};
      b_q    <= '{default: '0};
      s_q    <= '{default: '0};
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      vld_q  <= vld_d;
      c_q    <= c_d;
      a_q    <= a_d;
      b_q    <= b_d;
      s_q    <= s_d;
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

  assign in_ready  = advance;
  assign out_valid = vld_q[STAGES-1];
  assign sum       = s_q[STAGES-1];
  assign cout      = c_q[STAGES-1];
  assign overflow  = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Scoreboard bench for pipelined_addsub at default parameters (WIDTH=16, CHUNK=4).
module tb_pipelined_addsub;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        overflow;
  logic        zero;

  pipelined_addsub #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .overflow(overflow), .zero(zero)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] s;
    logic        c;
    logic        v;
    logic        z;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   run_cnt = 0;
  int   max_run = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Independent reference: plain 17-bit add, overflow from operand/result signs.
  function automatic exp_t model(input logic [15:0] x, input logic [15:0] y,
                                 input logic ci, input logic sb_sub);
    logic [15:0] ye;
    logic [16:0] f;
    exp_t e;
    ye  = sb_sub ? ~y : y;
    f   = {1'b0, x} + {1'b0, ye} + {16'd0, (sb_sub ? 1'b1 : ci)};
    e.s = f[15:0];
    e.c = f[16];
    e.v = (x[15] == ye[15]) && (f[15] != x[15]);
    e.z = (f[15:0] == 16'd0);
    return e;
  endfunction

  // Monitor: retire one result per handshake and compare against the queue head.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (out_valid === 1'b1) begin
        run_cnt++;
        if (run_cnt > max_run) max_run = run_cnt;
      end else begin
        run_cnt = 0;
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", {12'd0, sum, cout, overflow, zero}, 32'hDEAD);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("result{sum,c,v,z}", {13'd0, sum, cout, overflow, zero},
              {13'd0, e.s, e.c, e.v, e.z});
        end
      end
    end
  end

  // Present one transaction from posedge+1; returns at posedge+1 after acceptance.
  task automatic send(input logic [15:0] x, input logic [15:0] y, input logic ci,
                      input logic sb_sub, input exp_t e);
    logic acc;
    acc      = 1'b0;
    in_valid = 1'b1;
    a = x; b = y; cin = ci; sub = sb_sub;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      if (acc) sb.push_back(e);
      @(posedge clk);
      #1;
    end
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic exp_t mk(input logic [15:0] s, input logic c, input logic v, input logic z);
    exp_t e;
    e.s = s; e.c = c; e.v = v; e.z = z;
    return e;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] held;
    logic [15:0] ra, rb;
    logic        rc, rs;
    rst_n = 1'b0; out_ready = 1'b1; in_valid = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;

    // Reset with random inputs toggling
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'($urandom); a = 16'($urandom); b = 16'($urandom);
      cin = 1'($urandom); sub = 1'($urandom);
      @(negedge clk);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_sum", {16'd0, sum}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
    end
    #1;
    rst_n = 1'b1;
    in_valid = 1'b0;

    // First transaction and latency: valid after the 3rd edge following acceptance
    send(16'h0003, 16'h0004, 1'b1, 1'b0, mk(16'h0008, 1'b0, 1'b0, 1'b0));
    chk("lat_edge0", {31'd0, out_valid}, 32'd0);
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk);
      #1;
      chk("lat_edge", {31'd0, out_valid}, (i == 3) ? 32'd1 : 32'd0);
    end
    idle(3);

    // Directed vectors with hand-computed results
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0, mk(16'h0000, 1'b1, 1'b0, 1'b1));
    send(16'h8000, 16'h0001, 1'b0, 1'b1, mk(16'h7FFF, 1'b1, 1'b1, 1'b0));
    send(16'h0005, 16'h0005, 1'b1, 1'b1, mk(16'h0000, 1'b1, 1'b0, 1'b1));
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, mk(16'h8000, 1'b0, 1'b1, 1'b0));
    send(16'h0000, 16'h0001, 1'b1, 1'b1, mk(16'hFFFF, 1'b0, 1'b0, 1'b0));
    send(16'h1234, 16'h0FED, 1'b1, 1'b0, mk(16'h2222, 1'b0, 1'b0, 1'b0));
    idle(6);
    chk("directed_drained", sb.size(), 32'd0);

    // Back-to-back stream of 8
    max_run = 0;
    for (int i = 0; i < 8; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom); rs = 1'($urandom);
      send(ra, rb, rc, rs, model(ra, rb, rc, rs));
    end
    idle(6);
    chk("stream_run_len", max_run, 32'd8);
    chk("stream_drained", sb.size(), 32'd0);

    // Backpressure: 3-cycle out_ready drop mid-stream
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom); rs = 1'($urandom);
          send(ra, rb, rc, rs, model(ra, rb, rc, rs));
        end
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b0;
        held = 16'h0;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          if (i == 0) held = sum;
          chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
          chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
          chk("stall_sum_hold", {16'd0, sum}, {16'd0, held});
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    idle(8);
    chk("bp_drained", sb.size(), 32'd0);

    // Reset mid-flight: 3 accepted, first reaches the output, then reset
    for (int i = 0; i < 3; i++) begin
      ra = 16'($urandom); rb = 16'($urandom);
      send(ra, rb, 1'b0, 1'b0, model(ra, rb, 1'b0, 1'b0));
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_sum", {16'd0, sum}, 32'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("midrst_no_output", {31'd0, out_valid}, 32'd0);
    end
    @(posedge clk);
    #1;
    send(16'hABCD, 16'h0BCD, 1'b0, 1'b1, mk(16'hA000, 1'b1, 1'b0, 1'b0));
    idle(6);
    chk("final_drained", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
